// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard: E/M/W shadow pipeline of in-flight metadata driving stall, bypass selects and mult/div interlock.
// Outputs are combinational from tracked state plus D inputs; stall holds F/D and bubbles E, the shadow pipe never stalls.
module hazard_scoreboard #(
    parameter int REG_AW  = 5,
    parameter int TW      = 2,
    parameter int SRC_W   = 3,
    parameter int MD_LAT  = 5,
    parameter int DIV_LAT = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              d_valid,
    input  logic [REG_AW-1:0] d_rs,
    input  logic [REG_AW-1:0] d_rt,
    input  logic              d_use_rs,
    input  logic              d_use_rt,
    input  logic [TW-1:0]     d_tuse_rs,
    input  logic [TW-1:0]     d_tuse_rt,
    input  logic [REG_AW-1:0] d_dst,
    input  logic [TW-1:0]     d_tnew,
    input  logic [SRC_W-1:0]  d_src,
    input  logic              d_md_start,
    input  logic              d_md_div,
    input  logic              d_md_use,
    input  logic              flush_e,
    output logic              stall,
    output logic [1:0]        fwd_rs_d,
    output logic [1:0]        fwd_rt_d,
    output logic [1:0]        fwd_rs_e,
    output logic [1:0]        fwd_rt_e,
    output logic              fwd_rt_m,
    output logic [SRC_W-1:0]  src_e,
    output logic [SRC_W-1:0]  src_m,
    output logic [SRC_W-1:0]  src_w,
    output logic              md_busy
);

    localparam int MAX_LAT = (DIV_LAT > MD_LAT) ? DIV_LAT : MD_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] dst;
        logic [TW-1:0]     tnew;
        logic [SRC_W-1:0]  src;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic              use_rs;
        logic              use_rt;
        logic              md_start;
        logic              md_div;
    } entry_t;

    entry_t         ent_e, ent_m, ent_w;
    entry_t         d_entry;
    logic [CW-1:0]  md_cnt;
    logic           issue;
    logic           rs_req, rt_req, md_lock;

    function automatic logic hit(input entry_t e, input logic [REG_AW-1:0] r);
        return e.valid && (e.dst == r) && (r != '0);
    endfunction

    function automatic logic [TW-1:0] age(input logic [TW-1:0] t);
        return (t == '0) ? '0 : t - 1'b1;
    endfunction

    // Only the youngest matching producer counts; returns {stall_request, fwd_sel}.
    function automatic logic [2:0] resolve_d(input entry_t pe, input entry_t pm, input entry_t pw,
                                             input logic [REG_AW-1:0] r, input logic use_op,
                                             input logic [TW-1:0] tuse);
        logic [2:0]    res;
        logic [TW-1:0] t;
        logic [1:0]    sel;
        logic          found;
        res   = 3'b000;
        t     = '0;
        sel   = 2'b00;
        found = 1'b1;
        if (hit(pe, r)) begin
            t   = pe.tnew;
            sel = 2'b01;
        end else if (hit(pm, r)) begin
            t   = pm.tnew;
            sel = 2'b10;
        end else if (hit(pw, r)) begin
            t   = pw.tnew;
            sel = 2'b11;
        end else begin
            found = 1'b0;
        end
        if (use_op && found) begin
            if (t > tuse)
                res = 3'b100;
            else if (t == '0)
                res = {1'b0, sel};
        end
        return res;
    endfunction

    function automatic logic [1:0] resolve_e(input entry_t pm, input entry_t pw,
                                             input logic [REG_AW-1:0] r);
        logic [1:0] sel;
        sel = 2'b00;
        if (hit(pm, r) && pm.tnew == '0)
            sel = 2'b10;
        else if (hit(pw, r) && pw.tnew == '0)
            sel = 2'b11;
        return sel;
    endfunction

    always_comb begin
        d_entry          = '0;
        d_entry.valid    = 1'b1;
        d_entry.dst      = d_dst;
        d_entry.tnew     = d_tnew;
        d_entry.src      = d_src;
        d_entry.rs       = d_rs;
        d_entry.rt       = d_rt;
        d_entry.use_rs   = d_use_rs;
        d_entry.use_rt   = d_use_rt;
        d_entry.md_start = d_md_start;
        d_entry.md_div   = d_md_div;
    end

    always_comb begin
        {rs_req, fwd_rs_d} = resolve_d(ent_e, ent_m, ent_w, d_rs, d_use_rs, d_tuse_rs);
        {rt_req, fwd_rt_d} = resolve_d(ent_e, ent_m, ent_w, d_rt, d_use_rt, d_tuse_rt);
        md_lock = d_md_use && (md_busy || (ent_e.valid && ent_e.md_start));
        stall   = d_valid && (rs_req || rt_req || md_lock);
        issue   = d_valid && !stall && !flush_e;
    end

    always_comb begin
        fwd_rs_e = 2'b00;
        fwd_rt_e = 2'b00;
        if (ent_e.valid && ent_e.use_rs)
            fwd_rs_e = resolve_e(ent_m, ent_w, ent_e.rs);
        if (ent_e.valid && ent_e.use_rt)
            fwd_rt_e = resolve_e(ent_m, ent_w, ent_e.rt);
        fwd_rt_m = ent_m.valid && ent_m.use_rt && hit(ent_w, ent_m.rt) && (ent_w.tnew == '0);
    end

    assign src_e   = ent_e.valid ? ent_e.src : '0;
    assign src_m   = ent_m.valid ? ent_m.src : '0;
    assign src_w   = ent_w.valid ? ent_w.src : '0;
    assign md_busy = (md_cnt != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            ent_e <= '0;
            ent_m <= '0;
            ent_w <= '0;
        end else begin
            ent_e      <= issue ? d_entry : '0;
            ent_m      <= ent_e;
            ent_m.tnew <= age(ent_e.tnew);
            ent_w      <= ent_m;
            ent_w.tnew <= age(ent_m.tnew);
        end
    end

    // The busy count starts once the mult/div has occupied E for its cycle.
    always_ff @(posedge clk) begin
        if (reset)
            md_cnt <= '0;
        else if (ent_e.valid && ent_e.md_start)
            md_cnt <= ent_e.md_div ? CW'(DIV_LAT) : CW'(MD_LAT);
        else if (md_cnt != '0)
            md_cnt <= md_cnt - 1'b1;
    end

    logic unused_fields;
    assign unused_fields = ^{ent_m.rs, ent_m.use_rs, ent_m.md_start, ent_m.md_div,
                             ent_w.rs, ent_w.rt, ent_w.use_rs, ent_w.use_rt,
                             ent_w.md_start, ent_w.md_div};

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed pipeline scenarios then random traffic, checked against an age-based model.
module tb_hazard_scoreboard;
    localparam int REG_AW = 5, TW = 2, SRC_W = 3, MD_LAT = 5, DIV_LAT = 10;
    localparam int ALU = 1, HILO = 2, PC8 = 3, LOAD = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic d_valid = 1'b0, d_use_rs = 1'b0, d_use_rt = 1'b0;
    logic [REG_AW-1:0] d_rs = '0, d_rt = '0, d_dst = '0;
    logic [TW-1:0] d_tuse_rs = '0, d_tuse_rt = '0, d_tnew = '0;
    logic [SRC_W-1:0] d_src = '0;
    logic d_md_start = 1'b0, d_md_div = 1'b0, d_md_use = 1'b0, flush_e = 1'b0;
    logic stall, fwd_rt_m, md_busy;
    logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;
    logic [SRC_W-1:0] src_e, src_m, src_w;

    hazard_scoreboard #(.REG_AW(REG_AW), .TW(TW), .SRC_W(SRC_W), .MD_LAT(MD_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .reset(reset), .d_valid(d_valid), .d_rs(d_rs), .d_rt(d_rt),
        .d_use_rs(d_use_rs), .d_use_rt(d_use_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
        .d_dst(d_dst), .d_tnew(d_tnew), .d_src(d_src), .d_md_start(d_md_start),
        .d_md_div(d_md_div), .d_md_use(d_md_use), .flush_e(flush_e), .stall(stall),
        .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d), .fwd_rs_e(fwd_rs_e), .fwd_rt_e(fwd_rt_e),
        .fwd_rt_m(fwd_rt_m), .src_e(src_e), .src_m(src_m), .src_w(src_w), .md_busy(md_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic valid;
        int   dst, tnew, src, rs, rt, tuse_rs, tuse_rt;
        logic use_rs, use_rt, md_start, md_div, md_use;
    } ins_t;

    typedef struct {
        logic       stall, frtm, busy;
        logic [1:0] frsd, frtd, frse, frte;
        logic [2:0] se, sm, sw;
    } exp_t;

    exp_t expq[$];
    ins_t pipe[3];          // index = cycles since entering E
    logic have_md = 1'b0;
    int   md_c = 0, md_lat = 0, cyc = 0;
    int   checks = 0, errors = 0;

    function automatic ins_t nop();
        ins_t n;
        n = '{valid: 1'b0, dst: 0, tnew: 0, src: 0, rs: 0, rt: 0, tuse_rs: 0, tuse_rt: 0,
              use_rs: 1'b0, use_rt: 1'b0, md_start: 1'b0, md_div: 1'b0, md_use: 1'b0};
        return n;
    endfunction

    function automatic ins_t mk(int dst, int tnew, int src, int rs, logic urs, int trs,
                                int rt, logic urt, int trt);
        ins_t n;
        n = nop();
        n.valid = 1'b1; n.dst = dst; n.tnew = tnew; n.src = src;
        n.rs = rs; n.use_rs = urs; n.tuse_rs = trs;
        n.rt = rt; n.use_rt = urt; n.tuse_rt = trt;
        return n;
    endfunction

    // Cycles still to wait before the producer at age k can be forwarded.
    function automatic int remaining(int k);
        return (pipe[k].tnew > k) ? pipe[k].tnew - k : 0;
    endfunction

    function automatic void model_d(input int r, input logic u, input int tuse,
                                    output logic req, output logic [1:0] f);
        req = 1'b0;
        f   = 2'b00;
        if (!u || r == 0) return;
        for (int k = 0; k < 3; k++) begin
            if (pipe[k].valid && pipe[k].dst == r) begin
                if (remaining(k) > tuse) req = 1'b1;
                else if (remaining(k) == 0) f = 2'(k + 1);
                return;
            end
        end
    endfunction

    function automatic logic [1:0] model_e(input int r, input logic u, input int tuse);
        logic [1:0] f;
        logic       seen;
        f = 2'b00;
        seen = 1'b0;
        if (!pipe[0].valid || !u || r == 0) return 2'b00;
        for (int k = 1; k < 3; k++) begin
            if (pipe[k].valid && pipe[k].dst == r) begin
                if (!seen && tuse <= 1 && remaining(k) > 0) begin
                    errors++;
                    $display("FAIL illegal_fwd_e: reg %0d needed in E but producer age %0d not ready", r, k);
                end
                seen = 1'b1;
                if (f == 2'b00 && remaining(k) == 0) f = 2'(k + 1);
            end
        end
        return f;
    endfunction

    function automatic logic [2:0] src_of(int k);
        return pipe[k].valid ? 3'(pipe[k].src) : 3'd0;
    endfunction

    task automatic drive(input ins_t d, input logic rst, input logic fl, output logic st);
        exp_t e;
        logic rq_s, rq_t, lock;
        d_valid = d.valid; d_dst = d.dst[REG_AW-1:0]; d_tnew = d.tnew[TW-1:0];
        d_src = d.src[SRC_W-1:0]; d_rs = d.rs[REG_AW-1:0]; d_rt = d.rt[REG_AW-1:0];
        d_use_rs = d.use_rs; d_use_rt = d.use_rt;
        d_tuse_rs = d.tuse_rs[TW-1:0]; d_tuse_rt = d.tuse_rt[TW-1:0];
        d_md_start = d.md_start; d_md_div = d.md_div; d_md_use = d.md_use;
        reset = rst; flush_e = fl;
        model_d(d.rs, d.use_rs, d.tuse_rs, rq_s, e.frsd);
        model_d(d.rt, d.use_rt, d.tuse_rt, rq_t, e.frtd);
        e.busy  = have_md && cyc > md_c && cyc <= md_c + md_lat;
        lock    = d.md_use && (e.busy || (pipe[0].valid && pipe[0].md_start));
        e.stall = d.valid && (rq_s || rq_t || lock);
        e.frse  = model_e(pipe[0].rs, pipe[0].use_rs, pipe[0].tuse_rs);
        e.frte  = model_e(pipe[0].rt, pipe[0].use_rt, pipe[0].tuse_rt);
        e.frtm  = pipe[1].valid && pipe[1].use_rt && pipe[1].rt != 0 && pipe[2].valid &&
                  pipe[2].dst == pipe[1].rt && remaining(2) == 0;
        e.se = src_of(0); e.sm = src_of(1); e.sw = src_of(2);
        expq.push_back(e);
        st = e.stall;
        @(posedge clk);
        if (rst) begin
            for (int k = 0; k < 3; k++) pipe[k] = nop();
            have_md = 1'b0;
        end else begin
            if (pipe[0].valid && pipe[0].md_start) begin
                have_md = 1'b1;
                md_c    = cyc;
                md_lat  = pipe[0].md_div ? DIV_LAT : MD_LAT;
            end
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = (d.valid && !e.stall && !fl) ? d : nop();
        end
        cyc++;
        #1;
    endtask

    task automatic issue(input ins_t d);
        logic st;
        int   n;
        n = 0;
        do begin
            drive(d, 1'b0, 1'b0, st);
            n++;
        end while (st && n < 40);
        if (st) begin
            errors++;
            $display("FAIL issue_timeout: still stalled after %0d cycles, required issue", n);
        end
    endtask

    task automatic idle(input int n);
        logic st;
        for (int i = 0; i < n; i++) drive(nop(), 1'b0, 1'b0, st);
    endtask

    task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                cmp("stall", 8'(stall), 8'(e.stall));
                cmp("fwd_rs_d", 8'(fwd_rs_d), 8'(e.frsd));
                cmp("fwd_rt_d", 8'(fwd_rt_d), 8'(e.frtd));
                cmp("fwd_rs_e", 8'(fwd_rs_e), 8'(e.frse));
                cmp("fwd_rt_e", 8'(fwd_rt_e), 8'(e.frte));
                cmp("fwd_rt_m", 8'(fwd_rt_m), 8'(e.frtm));
                cmp("src_e", 8'(src_e), 8'(e.se));
                cmp("src_m", 8'(src_m), 8'(e.sm));
                cmp("src_w", 8'(src_w), 8'(e.sw));
                cmp("md_busy", 8'(md_busy), 8'(e.busy));
            end
        end
    end

    initial begin : stimulus
        logic st;
        ins_t d;
        for (int k = 0; k < 3; k++) pipe[k] = nop();
        @(posedge clk);
        #1;
        drive(nop(), 1'b1, 1'b0, st);
        drive(nop(), 1'b0, 1'b0, st);

        // ALU producer then branch compare in D
        issue(mk(3, 1, ALU, 1, 1'b1, 1, 2, 1'b1, 1));
        issue(mk(0, 0, 0, 3, 1'b1, 0, 4, 1'b1, 0));
        idle(3);
        // load-use into E
        issue(mk(5, 2, LOAD, 29, 1'b1, 1, 0, 1'b0, 0));
        issue(mk(6, 1, ALU, 5, 1'b1, 1, 0, 1'b0, 0));
        idle(3);
        // load then store of the loaded value
        issue(mk(5, 2, LOAD, 29, 1'b1, 1, 0, 1'b0, 0));
        issue(mk(0, 0, 0, 29, 1'b1, 1, 5, 1'b1, 2));
        idle(3);
        // jal then jr $31
        issue(mk(31, 0, PC8, 0, 1'b0, 0, 0, 1'b0, 0));
        issue(mk(0, 0, 0, 31, 1'b1, 0, 0, 1'b0, 0));
        idle(3);
        // full divide and multiply interlocks
        d = mk(0, 0, 0, 8, 1'b1, 1, 9, 1'b1, 1);
        d.md_start = 1'b1; d.md_div = 1'b1; d.md_use = 1'b1;
        issue(d);
        d = mk(10, 1, HILO, 0, 1'b0, 0, 0, 1'b0, 0);
        d.md_use = 1'b1;
        issue(d);
        d = mk(0, 0, 0, 8, 1'b1, 1, 9, 1'b1, 1);
        d.md_start = 1'b1; d.md_use = 1'b1;
        issue(d);
        d = mk(11, 1, HILO, 0, 1'b0, 0, 0, 1'b0, 0);
        d.md_use = 1'b1;
        issue(d);
        idle(2);
        // reset in the 4th busy cycle of a divide
        d = mk(0, 0, 0, 8, 1'b1, 1, 9, 1'b1, 1);
        d.md_start = 1'b1; d.md_div = 1'b1; d.md_use = 1'b1;
        issue(d);
        d = mk(10, 1, HILO, 0, 1'b0, 0, 0, 1'b0, 0);
        d.md_use = 1'b1;
        for (int i = 0; i < 4; i++) drive(d, 1'b0, 1'b0, st);
        drive(d, 1'b1, 1'b0, st);
        issue(d);
        idle(3);
        // $0 writers never forward; youngest producer wins
        for (int i = 0; i < 3; i++) issue(mk(0, 1, ALU, 1, 1'b1, 1, 2, 1'b1, 1));
        issue(mk(0, 0, 0, 0, 1'b1, 0, 0, 1'b1, 0));
        idle(3);
        issue(mk(7, 1, ALU, 1, 1'b1, 1, 0, 1'b0, 0));
        issue(mk(7, 1, ALU, 7, 1'b1, 1, 2, 1'b1, 1));
        issue(mk(0, 0, 0, 7, 1'b1, 0, 0, 1'b0, 0));
        idle(3);

        for (int i = 0; i < 1500; i++) begin
            d = nop();
            if ($urandom_range(9) < 8) begin
                d = mk($urandom_range(7), $urandom_range(2), $urandom_range(7),
                       $urandom_range(7), 1'($urandom_range(1)), $urandom_range(2),
                       $urandom_range(7), 1'($urandom_range(1)), $urandom_range(2));
                d.md_start = ($urandom_range(19) == 0);
                d.md_div   = 1'($urandom_range(1));
                d.md_use   = d.md_start || ($urandom_range(9) == 0);
            end
            drive(d, ($urandom_range(99) == 0), ($urandom_range(9) == 0), st);
        end
        idle(2);
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
